// File: rtl/gba_cart_bus_pkg.sv
// ============================================================================
// Module  : gba_cart_pkg
// Purpose : Shared types and constants for the GBA cartridge bus slave.
//           Holds the bus FSM state enum, the address/data widths and the
//           default halfword address of the control register bank.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package gba_cart_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] REG_BASE_DEF = 24'h000400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FETCH  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/gba_cart_bus_if.sv
// ============================================================================
// Module  : gba_cart_bus_if
// Purpose : Cartridge-side pin bundle of the GBA bus (raw strobes, upper
//           address pins and the multiplexed AD bus).
// Ports   : cs_n/rd_n/wr_n  raw active-low strobes (asynchronous)
//           a_hi            raw A[23:16]
//           ad_in           pad input of AD[15:0]
//           ad_out/ad_oe    pad output data and output enable
//           master modport = console/pad side, slave modport = cartridge logic
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface gba_cart_bus_if;
  import gba_cart_pkg::*;

  logic              cs_n;
  logic              rd_n;
  logic              wr_n;
  logic [7:0]        a_hi;
  logic [DATA_W-1:0] ad_in;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;

  modport master (
    output cs_n, rd_n, wr_n, a_hi, ad_in,
    input  ad_out, ad_oe
  );

  modport slave (
    input  cs_n, rd_n, wr_n, a_hi, ad_in,
    output ad_out, ad_oe
  );

endinterface

`default_nettype wire

// File: rtl/gba_edge_sync.sv
// ============================================================================
// Module  : gba_edge_sync
// Purpose : Synchroniser chain plus one history flop for an asynchronous
//           strobe, producing single-cycle fall and rise pulses. All flops
//           reset to 1 (strobe inactive) so reset release never fakes an edge.
// Ports   : clk, rst_n   clock / asynchronous active-low reset
//           d_i          raw asynchronous strobe
//           fall_o       one-cycle pulse on a 1->0 transition
//           rise_o       one-cycle pulse on a 0->1 transition
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gba_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic fall_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= w_level;
    end
  end

  assign w_level = sync_q[STAGES-1];
  assign fall_o  = hist_q & ~w_level;
  assign rise_o  = ~hist_q & w_level;

endmodule

`default_nettype wire

// File: rtl/gba_cart_bus.sv
// ============================================================================
// Module  : gba_cart_bus
// Purpose : GBA cartridge bus slave. Synchronises CS/RD/WR, latches the
//           24-bit halfword address, serves (burst) reads from a synchronous
//           ROM with ROM_LAT cycles latency, and implements NREG 16-bit
//           read/write control registers at REG_BASE. Everything else reads
//           back the low address half (open bus).
// Ports   : clk, rst_n    PLL clock / asynchronous active-low reset
//           bus           cartridge pins (slave modport)
//           rom_addr_o    ROM read address
//           rom_en_o      one-cycle ROM read strobe
//           rom_data_i    ROM data, valid ROM_LAT cycles after rom_en_o
//           reg_q_o       register contents, register i at [16i+15:16i]
//           reg_wstb_o    one-cycle write pulse per register
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gba_cart_bus
  import gba_cart_pkg::*;
#(
  parameter int                ROM_AW      = 10,
  parameter int                ROM_LAT     = 1,
  parameter int                NREG        = 4,
  parameter logic [ADDR_W-1:0] REG_BASE    = REG_BASE_DEF,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gba_cart_bus_if.slave          bus,
  output logic [ROM_AW-1:0]      rom_addr_o,
  output logic                   rom_en_o,
  input  logic [DATA_W-1:0]      rom_data_i,
  output logic [DATA_W*NREG-1:0] reg_q_o,
  output logic [NREG-1:0]        reg_wstb_o
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   ad_out_q;
  logic                rom_en_q;
  logic [ROM_AW-1:0]   rom_addr_q;
  logic [DATA_W*NREG-1:0] regs_q;
  logic [NREG-1:0]     wstb_q;
  logic [2:0]          cnt_q;
  logic                rd_pend_q;

  logic w_cs_fall, w_cs_rise;
  logic w_rd_fall, w_rd_rise;
  logic w_wr_fall, w_wr_rise;

  logic              w_rom_hit;
  logic [ADDR_W:0]   w_reg_off;
  logic              w_reg_hit;
  logic [DATA_W-1:0] w_reg_rdata;

  // Output enable bypasses the synchronisers so the bus is released at once.
  assign bus.ad_oe  = ~bus.cs_n & ~bus.rd_n;
  assign bus.ad_out = ad_out_q;

  gba_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d_i(bus.cs_n), .fall_o(w_cs_fall), .rise_o(w_cs_rise)
  );

  gba_edge_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk), .rst_n(rst_n), .d_i(bus.rd_n), .fall_o(w_rd_fall), .rise_o(w_rd_rise)
  );

  gba_edge_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk), .rst_n(rst_n), .d_i(bus.wr_n), .fall_o(w_wr_fall), .rise_o(w_wr_rise)
  );

  // Decode. The register offset is computed one bit wider so an address
  // below REG_BASE shows up as a set MSB instead of wrapping into range.
  assign w_rom_hit = ~|(addr_q >> ROM_AW);
  assign w_reg_off = {1'b0, addr_q} - {1'b0, REG_BASE};
  assign w_reg_hit = ~w_reg_off[ADDR_W] && (w_reg_off < (ADDR_W+1)'(NREG));

  always_comb begin
    w_reg_rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_reg_off == (ADDR_W+1)'(i)) begin
        w_reg_rdata = regs_q[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      ad_out_q   <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      regs_q     <= '0;
      wstb_q     <= '0;
      cnt_q      <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rom_en_q <= 1'b0;
      wstb_q   <= '0;

      if (w_cs_rise) begin
        // Deselect aborts whatever is in flight; addr and AD_OUT hold.
        state_q   <= IDLE;
        rd_pend_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (w_cs_fall) begin
              addr_q    <= {bus.a_hi, bus.ad_in};
              state_q   <= ACTIVE;
              // A read that fell together with CS launches next cycle,
              // once the new address is in addr_q.
              rd_pend_q <= w_rd_fall;
            end
          end

          ACTIVE: begin
            if (w_rd_fall || rd_pend_q) begin
              // Read wins over a simultaneous write; the write is dropped.
              rd_pend_q <= 1'b0;
              if (w_rom_hit) begin
                rom_en_q   <= 1'b1;
                rom_addr_q <= addr_q[ROM_AW-1:0];
                cnt_q      <= 3'(ROM_LAT);
                state_q    <= FETCH;
              end else if (w_reg_hit) begin
                ad_out_q <= w_reg_rdata;
              end else begin
                ad_out_q <= addr_q[DATA_W-1:0];
              end
            end else if (w_wr_fall && w_reg_hit) begin
              for (int i = 0; i < NREG; i++) begin
                if (w_reg_off == (ADDR_W+1)'(i)) begin
                  regs_q[DATA_W*i +: DATA_W] <= bus.ad_in;
                  wstb_q[i]                  <= 1'b1;
                end
              end
            end

            // Low half only: A[23:16] is fixed for the whole burst.
            if (w_rd_rise || w_wr_rise) begin
              addr_q[DATA_W-1:0] <= addr_q[DATA_W-1:0] + 16'd1;
            end
          end

          FETCH: begin
            if (w_rd_rise) begin
              // Console gave up on the read: drop the data, keep counting.
              addr_q[DATA_W-1:0] <= addr_q[DATA_W-1:0] + 16'd1;
              state_q            <= ACTIVE;
            end else if (cnt_q == 3'd0) begin
              ad_out_q <= rom_data_i;
              state_q  <= ACTIVE;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rom_en_o   = rom_en_q;
  assign rom_addr_o = rom_addr_q;
  assign reg_q_o    = regs_q;
  assign reg_wstb_o = wstb_q;

endmodule

`default_nettype wire

// File: tb/tb_gba_cart_bus.sv
// ============================================================================
// Module  : tb_gba_cart_bus
// Purpose : Self-checking bench for gba_cart_bus: table of single accesses
//           with constant expectations, directed multi-cycle sequences
//           (bursts, wrap, aborts, reset) and random bursts against a
//           transaction-level reference model of the cartridge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gba_cart_bus;

  localparam int NREG = 4;
  localparam int LAT  = 3;
  localparam int ROMN = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gba_cart_bus_if bus();

  logic [9:0]        rom_addr;
  logic              rom_en;
  logic [15:0]       rom_data;
  logic [16*NREG-1:0] reg_q;
  logic [NREG-1:0]   reg_wstb;

  gba_cart_bus #(
    .ROM_AW(10), .ROM_LAT(LAT), .NREG(NREG),
    .REG_BASE(24'h000400), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rom_addr_o(rom_addr), .rom_en_o(rom_en), .rom_data_i(rom_data),
    .reg_q_o(reg_q), .reg_wstb_o(reg_wstb)
  );

  // Synchronous ROM with LAT cycles of latency.
  logic [15:0] rom_mem [ROMN];
  logic [15:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_mem[rom_addr];
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  // Output monitors.
  int          rom_en_cnt = 0;
  logic [9:0]  last_rom_addr = '0;
  int          wstb_cycles = 0;
  logic [NREG-1:0] wstb_or = '0;
  always @(negedge clk) begin
    if (rom_en === 1'b1) begin
      rom_en_cnt++;
      last_rom_addr = rom_addr;
    end
    if (reg_wstb !== '0) begin
      wstb_cycles++;
      wstb_or = wstb_or | reg_wstb;
    end
  end

  // Reference model: cartridge seen as an address-indexed memory map.
  logic [23:0] m_addr;
  logic [15:0] m_regs [NREG];
  logic [15:0] m_ad;

  function automatic logic [15:0] m_read();
    int a = int'(m_addr);
    if (a < ROMN) return rom_mem[a];
    if (a >= 'h400 && a < 'h400 + NREG) return m_regs[a - 'h400];
    return m_addr[15:0];
  endfunction

  function automatic logic [63:0] m_regq();
    logic [63:0] v = '0;
    for (int i = 0; i < NREG; i++) v[16*i +: 16] = m_regs[i];
    return v;
  endfunction

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_begin(input logic [23:0] a, input bit with_rd);
    bus.a_hi  = a[23:16];
    bus.ad_in = a[15:0];
    bus.cs_n  = 1'b0;
    if (with_rd) bus.rd_n = 1'b0;
    m_addr = a;
    if (!with_rd) repeat (6) step();
  endtask

  task automatic cs_end();
    bus.cs_n = 1'b1;
    repeat (6) step();
  endtask

  task automatic rd_pulse(input bit pre_low);
    int          en0 = rom_en_cnt;
    logic [15:0] exp = m_read();
    bit          hit = int'(m_addr) < ROMN;
    bit          stable = 1'b1;
    bus.rd_n = 1'b0;
    #1;
    if (!pre_low) chk("ad_oe_rd", 64'(bus.ad_oe), 64'd1);
    repeat (14) step();
    chk("rd_data", 64'(bus.ad_out), 64'(exp));
    chk("rd_rom_en_count", 64'(rom_en_cnt - en0), hit ? 64'd1 : 64'd0);
    if (hit) chk("rd_rom_addr", 64'(last_rom_addr), 64'(m_addr[9:0]));
    bus.rd_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.ad_out !== exp) stable = 1'b0;
    end
    chk("rd_hold_after_rise", 64'(stable), 64'd1);
    m_addr[15:0] = m_addr[15:0] + 16'd1;
    m_ad = exp;
  endtask

  task automatic wr_pulse(input logic [15:0] d);
    int  w0;
    int  a = int'(m_addr);
    bit  hit = (a >= 'h400) && (a < 'h400 + NREG);
    bus.ad_in = d;
    step();
    w0 = wstb_cycles;
    wstb_or = '0;
    bus.wr_n = 1'b0;
    repeat (10) step();
    bus.wr_n = 1'b1;
    repeat (6) step();
    if (hit) m_regs[a - 'h400] = d;
    chk("wr_reg_q", 64'(reg_q), m_regq());
    chk("wr_wstb_cycles", 64'(wstb_cycles - w0), hit ? 64'd1 : 64'd0);
    chk("wr_wstb_mask", 64'(wstb_or), hit ? (64'd1 << (a - 'h400)) : 64'd0);
    m_addr[15:0] = m_addr[15:0] + 16'd1;
  endtask

  task automatic rdwr_pulse(input logic [15:0] d);
    int          w0;
    logic [15:0] exp = m_read();
    bus.ad_in = d;
    step();
    w0 = wstb_cycles;
    bus.rd_n = 1'b0;
    bus.wr_n = 1'b0;
    repeat (14) step();
    chk("rdwr_data", 64'(bus.ad_out), 64'(exp));
    bus.rd_n = 1'b1;
    bus.wr_n = 1'b1;
    repeat (6) step();
    chk("rdwr_no_write", 64'(reg_q), m_regq());
    chk("rdwr_no_wstb", 64'(wstb_cycles - w0), 64'd0);
    m_addr[15:0] = m_addr[15:0] + 16'd1;
    m_ad = exp;
  endtask

  // Wait for the ROM strobe with the read pin held low; bounded.
  task automatic wait_rom_en(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (rom_en === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("rom_en_timeout", 64'd0, 64'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    bit seen;
    int en0, w0;
    logic [15:0] hold;

    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    bus.a_hi = '0;   bus.ad_in = '0;
    for (int i = 0; i < ROMN; i++) rom_mem[i] = 16'($urandom);
    rom_mem[10'h000] = 16'hA5A5;
    rom_mem[10'h010] = 16'h0F0F;
    rom_mem[10'h012] = 16'hBEEF;
    rom_mem[10'h3FE] = 16'h1111;
    rom_mem[10'h3FF] = 16'h2222;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_addr = '0;
    m_ad   = '0;

    // Reset state.
    repeat (3) step();
    chk("rst_ad_out", 64'(bus.ad_out), 64'd0);
    chk("rst_rom_en", 64'(rom_en), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
    chk("rst_reg_q", 64'(reg_q), 64'd0);
    chk("rst_wstb", 64'(reg_wstb), 64'd0);
    chk("rst_ad_oe", 64'(bus.ad_oe), 64'd0);
    rst_n = 1'b1;
    repeat (6) step();
    chk("rst_release_no_rom_en", 64'(rom_en_cnt), 64'd0);

    // Table of single-access transactions with constant expectations.
    vecs[0] = '{1'b0, 24'h000012, 16'h0000, 16'hBEEF};
    vecs[1] = '{1'b0, 24'h000000, 16'h0000, 16'hA5A5};
    vecs[2] = '{1'b1, 24'h000400, 16'h03FF, 16'h03FF};
    vecs[3] = '{1'b1, 24'h000403, 16'h1234, 16'h1234};
    vecs[4] = '{1'b1, 24'h000404, 16'h7777, 16'h0404};
    vecs[5] = '{1'b1, 24'h000010, 16'h9999, 16'h0F0F};
    vecs[6] = '{1'b0, 24'h12FFFF, 16'h0000, 16'hFFFF};
    vecs[7] = '{1'b0, 24'h010012, 16'h0000, 16'h0012};
    vecs[8] = '{1'b0, 24'h000401, 16'h0000, 16'h0000};
    vecs[9] = '{1'b0, 24'h000400, 16'h0000, 16'h03FF};
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].wr) begin
        cs_begin(vecs[v].addr, 1'b0);
        wr_pulse(vecs[v].wdata);
        cs_end();
      end
      cs_begin(vecs[v].addr, 1'b0);
      rd_pulse(1'b0);
      cs_end();
      chk($sformatf("vec%0d", v), 64'(bus.ad_out), 64'(vecs[v].exp));
    end

    // Single ROM read followed by the sequential halfword.
    cs_begin(24'h000012, 1'b0);
    rd_pulse(1'b0);
    rd_pulse(1'b0);
    chk("seq_after_0x12", 64'(bus.ad_out), 64'(rom_mem[10'h013]));
    cs_end();

    // Burst crossing from ROM into the register window.
    m_regs[1] = m_regs[1];
    cs_begin(24'h0003FE, 1'b0);
    for (int i = 0; i < 4; i++) rd_pulse(1'b0);
    chk("burst_last_reg1", 64'(bus.ad_out), 64'(m_regs[1]));
    cs_end();

    // Open-bus wrap keeps A_HI, low-half wrap inside bank 0 lands on ROM[0].
    cs_begin(24'h12FFFF, 1'b0);
    rd_pulse(1'b0);
    rd_pulse(1'b0);
    chk("wrap_open_bus", 64'(bus.ad_out), 64'h0000);
    cs_end();
    cs_begin(24'h00FFFF, 1'b0);
    rd_pulse(1'b0);
    rd_pulse(1'b0);
    chk("wrap_into_rom0", 64'(bus.ad_out), 64'hA5A5);
    cs_end();

    // CS fall and RD fall together: read uses the freshly latched address.
    cs_begin(24'h000401, 1'b1);
    rd_pulse(1'b1);
    cs_end();
    cs_begin(24'h000012, 1'b1);
    rd_pulse(1'b1);
    chk("cs_rd_same_rom", 64'(bus.ad_out), 64'hBEEF);
    cs_end();

    // RD fall and WR fall together: read serviced, write dropped.
    cs_begin(24'h000403, 1'b0);
    rdwr_pulse(16'hDEAD);
    cs_end();

    // RD rises right after ROM_EN: fetch aborted, addr still advances.
    cs_begin(24'h000012, 1'b0);
    hold = bus.ad_out;
    bus.rd_n = 1'b0;
    wait_rom_en(seen);
    bus.rd_n = 1'b1;
    repeat (10) step();
    chk("rd_abort_ad_hold", 64'(bus.ad_out), 64'(hold));
    m_addr[15:0] = m_addr[15:0] + 16'd1;
    rd_pulse(1'b0);
    chk("rd_abort_addr_inc", 64'(bus.ad_out), 64'(rom_mem[10'h013]));
    cs_end();

    // CS rises right after ROM_EN: fetch aborted, back to idle.
    cs_begin(24'h000000, 1'b0);
    hold = bus.ad_out;
    w0 = wstb_cycles;
    bus.rd_n = 1'b0;
    wait_rom_en(seen);
    bus.cs_n = 1'b1;
    repeat (10) step();
    bus.rd_n = 1'b1;
    repeat (6) step();
    chk("cs_abort_ad_hold", 64'(bus.ad_out), 64'(hold));
    chk("cs_abort_no_wstb", 64'(wstb_cycles - w0), 64'd0);
    en0 = rom_en_cnt;
    bus.rd_n = 1'b0;
    repeat (10) step();
    bus.rd_n = 1'b1;
    repeat (6) step();
    chk("idle_ignores_rd", 64'(rom_en_cnt - en0), 64'd0);
    chk("idle_ad_hold", 64'(bus.ad_out), 64'(hold));

    // Random bursts against the reference model.
    for (int b = 0; b < 40; b++) begin
      logic [23:0] a;
      int sel = $urandom_range(0, 3);
      case (sel)
        0: a = 24'($urandom_range(0, ROMN - 1));
        1: a = 24'($urandom_range('h3FC, 'h3FF));
        2: a = 24'($urandom_range('h3FE, 'h405));
        default: a = 24'($urandom);
      endcase
      cs_begin(a, 1'b0);
      for (int k = 0, n = $urandom_range(1, 4); k < n; k++) begin
        int op = $urandom_range(0, 19);
        if (op < 13)      rd_pulse(1'b0);
        else if (op < 19) wr_pulse(16'($urandom));
        else              rdwr_pulse(16'($urandom));
      end
      cs_end();
    end

    // Reset during a fetch.
    cs_begin(24'h000012, 1'b0);
    bus.rd_n = 1'b0;
    wait_rom_en(seen);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ad_out", 64'(bus.ad_out), 64'd0);
    chk("midrst_rom_en", 64'(rom_en), 64'd0);
    chk("midrst_rom_addr", 64'(rom_addr), 64'd0);
    chk("midrst_reg_q", 64'(reg_q), 64'd0);
    chk("midrst_wstb", 64'(reg_wstb), 64'd0);
    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    repeat (3) step();
    rst_n = 1'b1;
    en0 = rom_en_cnt;
    w0  = wstb_cycles;
    repeat (12) step();
    chk("postrst_no_rom_en", 64'(rom_en_cnt - en0), 64'd0);
    chk("postrst_no_wstb", 64'(wstb_cycles - w0), 64'd0);
    chk("postrst_ad_out", 64'(bus.ad_out), 64'd0);
    cs_begin(24'h000400, 1'b0);
    rd_pulse(1'b0);
    cs_end();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
